// File: rtl/qspi_pkg.sv
// Shared types and helpers for the QSPI phase sequencer and its sibling shift registers.
package qspi_pkg;

  localparam int unsigned CMD_BITS = 8;
  localparam int unsigned CNT_W    = 6;
  localparam int unsigned LEN_W    = 9;
  localparam int unsigned DUMMY_W  = 5;
  localparam int unsigned LANE_W   = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DUMMY = 3'd3,
    ST_DATA  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  typedef logic [LANE_W-1:0] lane_code_t;

  // SCLK cycles needed to move `bits` over the lanes selected by `code` (11 behaves as single lane).
  function automatic logic [CNT_W-1:0] lanes_to_cycles(input logic [CNT_W-1:0] bits,
                                                       input lane_code_t code);
    case (code)
      2'b01:   return CNT_W'(bits >> 1);
      2'b10:   return CNT_W'(bits >> 2);
      default: return bits;
    endcase
  endfunction

  // One-hot {4,2,1} lane mode for a lane code.
  function automatic logic [2:0] lane_onehot(input lane_code_t code);
    case (code)
      2'b01:   return 3'b010;
      2'b10:   return 3'b100;
      default: return 3'b001;
    endcase
  endfunction

endpackage

// File: rtl/qspi_phase_sequencer.sv
// Sequences CMD / ADDR / DUMMY / DATA phases of a QSPI transaction, one step per SCLK tick,
// and drives chip select, SCLK gating, lane mode and per-phase shift strobes.
module qspi_phase_sequencer
  import qspi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       shift_tick,
  input  logic [1:0] cmd_lanes_in,
  input  logic [1:0] addr_lanes_in,
  input  logic [1:0] data_lanes_in,
  input  logic       addr_en_in,
  input  logic       addrOF4B_in,
  input  logic [4:0] dummy_cycles_in,
  input  logic [8:0] data_len_in,
  output logic       cmd_load,
  output logic       addr_load,
  output logic       cmd_shift_en,
  output logic       addr_shift_en,
  output logic       data_shift_en,
  output logic       use_1_io_lines_out,
  output logic       use_2_io_lines_out,
  output logic       use_4_io_lines_out,
  output logic       addrOF4B_out,
  output logic       cs_n,
  output logic       sclk_en,
  output logic       busy,
  output logic       done,
  output logic       byte_tick,
  output logic [2:0] phase_out
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   byte_cnt_q, byte_cnt_d;
  lane_code_t         cmd_lanes_q, cmd_lanes_d;
  lane_code_t         addr_lanes_q, addr_lanes_d;
  lane_code_t         data_lanes_q, data_lanes_d;
  logic               addr_en_q, addr_en_d;
  logic               addr4b_q, addr4b_d;
  logic [DUMMY_W-1:0] dummy_q, dummy_d;
  logic [LEN_W-1:0]   len_q, len_d;

  logic [CNT_W-1:0]   phase_len_c;
  logic               tick_last_c;
  logic               accept_c;
  state_e             after_cmd_c, after_addr_c, after_dummy_c;
  logic [2:0]         lanes_oh_c;

  assign accept_c = start && (state_q == ST_IDLE);

  // Skipped phases collapse forward in the fixed order.
  assign after_dummy_c = (len_q != '0)   ? ST_DATA  : ST_DONE;
  assign after_addr_c  = (dummy_q != '0) ? ST_DUMMY : after_dummy_c;
  assign after_cmd_c   = addr_en_q       ? ST_ADDR  : after_addr_c;

  // DATA length is per byte; the byte counter covers the rest.
  always_comb begin
    phase_len_c = '0;
    case (state_q)
      ST_CMD:   phase_len_c = lanes_to_cycles(CNT_W'(CMD_BITS), cmd_lanes_q);
      ST_ADDR:  phase_len_c = lanes_to_cycles(addr4b_q ? 6'd32 : 6'd24, addr_lanes_q);
      ST_DUMMY: phase_len_c = {1'b0, dummy_q};
      ST_DATA:  phase_len_c = lanes_to_cycles(CNT_W'(CMD_BITS), data_lanes_q);
      default:  phase_len_c = '0;
    endcase
  end

  assign tick_last_c = shift_tick && (cnt_q == phase_len_c - 6'd1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    byte_cnt_d   = byte_cnt_q;
    cmd_lanes_d  = cmd_lanes_q;
    addr_lanes_d = addr_lanes_q;
    data_lanes_d = data_lanes_q;
    addr_en_d    = addr_en_q;
    addr4b_d     = addr4b_q;
    dummy_d      = dummy_q;
    len_d        = len_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cmd_lanes_d  = cmd_lanes_in;
          addr_lanes_d = addr_lanes_in;
          data_lanes_d = data_lanes_in;
          addr_en_d    = addr_en_in;
          addr4b_d     = addrOF4B_in;
          dummy_d      = dummy_cycles_in;
          len_d        = data_len_in;
          cnt_d        = '0;
          byte_cnt_d   = '0;
          state_d      = ST_CMD;
        end
      end
      ST_CMD, ST_ADDR, ST_DUMMY: begin
        if (tick_last_c) begin
          cnt_d = '0;
          case (state_q)
            ST_CMD:  state_d = after_cmd_c;
            ST_ADDR: state_d = after_addr_c;
            default: state_d = after_dummy_c;
          endcase
        end else if (shift_tick) begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      ST_DATA: begin
        if (tick_last_c) begin
          cnt_d = '0;
          if (byte_cnt_q == len_q - 9'd1) begin
            byte_cnt_d = '0;
            state_d    = ST_DONE;
          end else begin
            byte_cnt_d = byte_cnt_q + 9'd1;
          end
        end else if (shift_tick) begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides any phase advance.
    if (abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      byte_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      byte_cnt_q   <= '0;
      cmd_lanes_q  <= '0;
      addr_lanes_q <= '0;
      data_lanes_q <= '0;
      addr_en_q    <= 1'b0;
      addr4b_q     <= 1'b0;
      dummy_q      <= '0;
      len_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      cmd_lanes_q  <= cmd_lanes_d;
      addr_lanes_q <= addr_lanes_d;
      data_lanes_q <= data_lanes_d;
      addr_en_q    <= addr_en_d;
      addr4b_q     <= addr4b_d;
      dummy_q      <= dummy_d;
      len_q        <= len_d;
    end
  end

  always_comb begin
    lanes_oh_c = 3'b000;
    case (state_q)
      ST_CMD:  lanes_oh_c = lane_onehot(cmd_lanes_q);
      ST_ADDR: lanes_oh_c = lane_onehot(addr_lanes_q);
      ST_DATA: lanes_oh_c = lane_onehot(data_lanes_q);
      default: lanes_oh_c = 3'b000;
    endcase
  end

  assign cmd_load           = accept_c;
  assign addr_load          = accept_c;
  assign cmd_shift_en       = shift_tick && (state_q == ST_CMD);
  assign addr_shift_en      = shift_tick && (state_q == ST_ADDR);
  assign data_shift_en      = shift_tick && (state_q == ST_DATA);
  assign use_1_io_lines_out = lanes_oh_c[0];
  assign use_2_io_lines_out = lanes_oh_c[1];
  assign use_4_io_lines_out = lanes_oh_c[2];
  assign addrOF4B_out       = addr4b_q;
  assign sclk_en            = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                              (state_q == ST_DUMMY) || (state_q == ST_DATA);
  assign cs_n               = !sclk_en;
  assign busy               = (state_q != ST_IDLE);
  assign done               = (state_q == ST_DONE);
  assign byte_tick          = (state_q == ST_DATA) && tick_last_c;
  assign phase_out          = state_q;

endmodule

// File: tb/tb_qspi_phase_sequencer.sv
// Directed bench for qspi_phase_sequencer: per-phase tick counts, abort, reset and lane decoding.
module tb_qspi_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, shift_tick;
  logic [1:0] cmd_lanes_in, addr_lanes_in, data_lanes_in;
  logic       addr_en_in, addrOF4B_in;
  logic [4:0] dummy_cycles_in;
  logic [8:0] data_len_in;
  logic       cmd_load, addr_load, cmd_shift_en, addr_shift_en, data_shift_en;
  logic       use_1_io_lines_out, use_2_io_lines_out, use_4_io_lines_out;
  logic       addrOF4B_out, cs_n, sclk_en, busy, done, byte_tick;
  logic [2:0] phase_out;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  qspi_phase_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .shift_tick(shift_tick),
    .cmd_lanes_in(cmd_lanes_in), .addr_lanes_in(addr_lanes_in), .data_lanes_in(data_lanes_in),
    .addr_en_in(addr_en_in), .addrOF4B_in(addrOF4B_in), .dummy_cycles_in(dummy_cycles_in),
    .data_len_in(data_len_in), .cmd_load(cmd_load), .addr_load(addr_load),
    .cmd_shift_en(cmd_shift_en), .addr_shift_en(addr_shift_en), .data_shift_en(data_shift_en),
    .use_1_io_lines_out(use_1_io_lines_out), .use_2_io_lines_out(use_2_io_lines_out),
    .use_4_io_lines_out(use_4_io_lines_out), .addrOF4B_out(addrOF4B_out), .cs_n(cs_n),
    .sclk_en(sclk_en), .busy(busy), .done(done), .byte_tick(byte_tick), .phase_out(phase_out)
  );

  // Mid-cycle monitor: counts strobes and records lane modes seen per phase.
  logic mon_clr = 1'b0;
  int   m_cmd, m_addr, m_dummy, m_data, m_cs, m_done, m_byte, m_load, m_dummy_seen;
  logic [2:0] m_cmd_lanes, m_data_lanes, m_dummy_lanes;

  always @(negedge clk) begin
    if (mon_clr) begin
      m_cmd <= 0; m_addr <= 0; m_dummy <= 0; m_data <= 0; m_cs <= 0;
      m_done <= 0; m_byte <= 0; m_load <= 0; m_dummy_seen <= 0;
      m_cmd_lanes <= 3'b000; m_data_lanes <= 3'b000; m_dummy_lanes <= 3'b000;
    end else begin
      if (cmd_shift_en)  m_cmd  <= m_cmd + 1;
      if (addr_shift_en) m_addr <= m_addr + 1;
      if (data_shift_en) m_data <= m_data + 1;
      if (shift_tick && phase_out == 3'd3) m_dummy <= m_dummy + 1;
      if (shift_tick && !cs_n) m_cs <= m_cs + 1;
      if (done)      m_done <= m_done + 1;
      if (byte_tick) m_byte <= m_byte + 1;
      if (cmd_load)  m_load <= m_load + 1;
      if (phase_out == 3'd3) begin
        m_dummy_seen  <= m_dummy_seen + 1;
        m_dummy_lanes <= m_dummy_lanes | {use_4_io_lines_out, use_2_io_lines_out, use_1_io_lines_out};
      end
      if (phase_out == 3'd1)
        m_cmd_lanes <= m_cmd_lanes | {use_4_io_lines_out, use_2_io_lines_out, use_1_io_lines_out};
      if (phase_out == 3'd4)
        m_data_lanes <= m_data_lanes | {use_4_io_lines_out, use_2_io_lines_out, use_1_io_lines_out};
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cfg(input logic [1:0] cl, input logic [1:0] al, input logic [1:0] dl,
                     input logic aen, input logic a4, input logic [4:0] dmy, input logic [8:0] len);
    cmd_lanes_in = cl; addr_lanes_in = al; data_lanes_in = dl;
    addr_en_in = aen; addrOF4B_in = a4; dummy_cycles_in = dmy; data_len_in = len;
  endtask

  // Clears the monitor, pulses start and checks the accept cycle and CMD entry.
  task automatic start_txn(input string tag);
    mon_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
    start = 1'b1;
    @(negedge clk);
    check({tag, "_cmd_load"}, int'(cmd_load), 1);
    check({tag, "_addr_load"}, int'(addr_load), 1);
    check({tag, "_busy_pre"}, int'(busy), 0);
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_phase_cmd"}, int'(phase_out), 1);
    check({tag, "_cs_low"}, int'(cs_n), 0);
    check({tag, "_sclk_en"}, int'(sclk_en), 1);
  endtask

  // Runs ticks until IDLE; optional abort on the abort_at-th ADDR tick and a start while busy.
  task automatic run_txn(input string tag, input int abort_at, input bit busy_start);
    bit finished = 1'b0;
    logic [1:0] saved = cmd_lanes_in;
    shift_tick = 1'b1;
    for (int n = 0; n < 400 && !finished; n++) begin
      if (abort_at != 0 && phase_out == 3'd2 && m_addr == abort_at - 1) abort = 1'b1;
      if (busy_start && phase_out == 3'd1 && m_cmd == 2) begin
        start = 1'b1;
        cmd_lanes_in = 2'b10;
      end
      @(posedge clk); #1;
      abort = 1'b0;
      start = 1'b0;
      cmd_lanes_in = saved;
      if (phase_out == 3'd0) finished = 1'b1;
    end
    shift_tick = 1'b0;
    check({tag, "_completed"}, int'(finished), 1);
    check({tag, "_cs_idle"}, int'(cs_n), 1);
    check({tag, "_busy_idle"}, int'(busy), 0);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; shift_tick = 1'b0;
    cfg(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 9'd0);
    #23;
    check("rst_phase", int'(phase_out), 0);
    check("rst_cs_n", int'(cs_n), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_sclk_en", int'(sclk_en), 0);
    rst_n = 1'b1;

    // Test 1: 1-1-1, 24-bit address, dummy 8, one byte
    cfg(2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 5'd8, 9'd1);
    start_txn("t1");
    check("t1_cmd_lanes_early", {29'd0, use_4_io_lines_out, use_2_io_lines_out, use_1_io_lines_out}, 1);
    run_txn("t1", 0, 1'b0);
    check("t1_cmd", m_cmd, 8);
    check("t1_addr", m_addr, 24);
    check("t1_dummy", m_dummy, 8);
    check("t1_data", m_data, 8);
    check("t1_cs_ticks", m_cs, 48);
    check("t1_done", m_done, 1);
    check("t1_bytes", m_byte, 1);
    check("t1_dummy_lanes", int'(m_dummy_lanes), 0);
    check("t1_addr4b", int'(addrOF4B_out), 0);

    // Test 2: 4-4-4, 32-bit address, no dummy, four bytes
    cfg(2'b10, 2'b10, 2'b10, 1'b1, 1'b1, 5'd0, 9'd4);
    start_txn("t2");
    run_txn("t2", 0, 1'b0);
    check("t2_cmd", m_cmd, 2);
    check("t2_addr", m_addr, 8);
    check("t2_data", m_data, 8);
    check("t2_bytes", m_byte, 4);
    check("t2_dummy_seen", m_dummy_seen, 0);
    check("t2_done", m_done, 1);
    check("t2_cmd_lanes", int'(m_cmd_lanes), 4);
    check("t2_data_lanes", int'(m_data_lanes), 4);
    check("t2_addr4b", int'(addrOF4B_out), 1);

    // Test 2b: 2-lane data, odd length
    cfg(2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 5'd3, 9'd3);
    start_txn("t2b");
    run_txn("t2b", 0, 1'b0);
    check("t2b_cmd", m_cmd, 4);
    check("t2b_addr", m_addr, 12);
    check("t2b_dummy", m_dummy, 3);
    check("t2b_data", m_data, 12);
    check("t2b_bytes", m_byte, 3);
    check("t2b_data_lanes", int'(m_data_lanes), 2);

    // Test 3: command only
    cfg(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 9'd0);
    start_txn("t3");
    run_txn("t3", 0, 1'b0);
    check("t3_cmd", m_cmd, 8);
    check("t3_addr", m_addr, 0);
    check("t3_data", m_data, 0);
    check("t3_done", m_done, 1);

    // Test 4: abort on the 5th ADDR tick, then a fresh start
    cfg(2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 5'd0, 9'd1);
    start_txn("t4");
    run_txn("t4", 5, 1'b0);
    check("t4_addr", m_addr, 5);
    check("t4_done", m_done, 0);
    check("t4_data", m_data, 0);
    cfg(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 9'd0);
    start_txn("t4r");
    run_txn("t4r", 0, 1'b0);
    check("t4r_cmd", m_cmd, 8);
    check("t4r_done", m_done, 1);

    // Test 5a: start while busy is ignored
    cfg(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 9'd1);
    start_txn("t5b");
    run_txn("t5b", 0, 1'b1);
    check("t5b_loads", m_load, 1);
    check("t5b_cmd", m_cmd, 8);
    check("t5b_cmd_lanes", int'(m_cmd_lanes), 1);
    check("t5b_data", m_data, 8);

    // Test 5b: lane code 11 behaves as single lane
    cfg(2'b11, 2'b11, 2'b11, 1'b1, 1'b0, 5'd0, 9'd1);
    start_txn("t5l");
    check("t5l_use1", int'(use_1_io_lines_out), 1);
    run_txn("t5l", 0, 1'b0);
    check("t5l_cmd", m_cmd, 8);
    check("t5l_addr", m_addr, 24);
    check("t5l_cmd_lanes", int'(m_cmd_lanes), 1);

    // Test 5c: asynchronous reset in the middle of DATA
    cfg(2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 5'd2, 9'd2);
    start_txn("t5r");
    shift_tick = 1'b1;
    for (int n = 0; n < 200 && !(phase_out == 3'd4 && m_data >= 3); n++) begin
      @(posedge clk); #1;
    end
    check("t5r_in_data", int'(phase_out), 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5r_phase", int'(phase_out), 0);
    check("t5r_cs_n", int'(cs_n), 1);
    check("t5r_sclk_en", int'(sclk_en), 0);
    check("t5r_busy", int'(busy), 0);
    check("t5r_data_shift", int'(data_shift_en), 0);
    check("t5r_lanes", {29'd0, use_4_io_lines_out, use_2_io_lines_out, use_1_io_lines_out}, 0);
    check("t5r_addr4b", int'(addrOF4B_out), 0);
    check("t5r_byte_tick", int'(byte_tick), 0);
    shift_tick = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t5r_post_phase", int'(phase_out), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
